pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 148 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Brings up the fabric PLL and supervises it: holds RESETB, qualifies lock, releases the
// fabric reset after stable lock, retries on failure and latches a fault when retries run out.
`timescale 1ns / 1ps

module pll_lock_sequencer #(
  parameter int unsigned RESET_HOLD    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int unsigned MaxA     = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
  localparam int unsigned MaxParam = (MaxA > STABLE_CYCLES) ? MaxA : STABLE_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxParam + 1);

  localparam logic [CntW-1:0] HoldLast   = CntW'(RESET_HOLD - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StResetPll  = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StRun       = 3'd3,
    StFault     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            sync1_q, lock_s;
  logic            pll_resetb_q, sys_reset_n_q, ready_q, fault_q;
  logic            attempt_fail;

  // Two-flop synchronizer; pll_locked is asynchronous to the reference clock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lock_s  <= sync1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    loss_d       = loss_q;
    attempt_fail = 1'b0;

    unique case (state_q)
      StResetPll: begin
        if (cnt_q == HoldLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s) state_d = StStabilize;
        else if (cnt_q == TimeoutLast) attempt_fail = 1'b1;
      end
      StStabilize: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = 8'd0;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StResetPll;
          retry_d = 8'd0;
          if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
        end
      end
      StFault: ;
      default: state_d = StResetPll;
    endcase

    if (attempt_fail) begin
      if (32'(retry_q) < MAX_RETRIES) begin
        state_d = StResetPll;
        if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
      end else begin
        state_d = StFault;
      end
    end

    // Host restart overrides everything decided above, including a coincident lock loss.
    if (relock_req) begin
      state_d = StResetPll;
      retry_d = 8'd0;
      loss_d  = loss_q;
    end

    if (relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q inside {StResetPll, StWaitLock, StStabilize}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs are decoded from the next state so they move on the entering edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StResetPll;
      cnt_q         <= '0;
      retry_q       <= 8'd0;
      loss_q        <= 8'd0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      pll_resetb_q  <= !((state_d == StResetPll) || (state_d == StFault));
      sys_reset_n_q <= (state_d == StRun);
      ready_q       <= (state_d == StRun);
      fault_q       <= (state_d == StFault);
    end
  end

  assign pll_resetb      = pll_resetb_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with default parameters; edge numbers are counted
// from the last edge that samples reset low (edge 0).
`timescale 1ns / 1ps

module tb_pll_lock_sequencer;

  logic       clock;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int e      = 0;
  int base, s, r;

  pll_lock_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_resetb     (pll_resetb),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".state"}, state, 0);
    check_eq({tag, ".pll_resetb"}, pll_resetb, 0);
    check_eq({tag, ".sys_reset_n"}, sys_reset_n, 0);
    check_eq({tag, ".ready"}, ready, 0);
    check_eq({tag, ".fault"}, fault, 0);
    check_eq({tag, ".retry"}, retry_count, 0);
    check_eq({tag, ".loss"}, lock_loss_count, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    check_reset_values("rst");

    // Clean lock: PLL locks 300 cycles after pll_resetb rises.
    e = 0;
    reset_n = 1'b1;
    run_to(15);  check_eq("clean.resetb_low", pll_resetb, 0);
    run_to(16);  check_eq("clean.resetb_high", pll_resetb, 1);
    check_eq("clean.wait_state", state, 1);
    run_to(315); pll_locked = 1'b1;
    run_to(317); check_eq("clean.still_wait", state, 1);
    run_to(318); check_eq("clean.stabilize", state, 2);
    run_to(573); check_eq("clean.not_ready", ready, 0);
    run_to(574); check_eq("clean.ready", ready, 1);
    check_eq("clean.sys_reset_n", sys_reset_n, 1);
    check_eq("clean.run", state, 3);
    check_eq("clean.retry", retry_count, 0);

    // Lock loss in RUN, then re-lock.
    base = e;
    pll_locked = 1'b0;
    run_to(base + 2); check_eq("loss.sys_still_high", sys_reset_n, 1);
    run_to(base + 3); check_eq("loss.sys_low", sys_reset_n, 0);
    check_eq("loss.resetb_low", pll_resetb, 0);
    check_eq("loss.state", state, 0);
    check_eq("loss.count", lock_loss_count, 1);
    pll_locked = 1'b1;
    base = e;
    run_to(base + 16);  check_eq("loss.relock_wait", state, 1);
    run_to(base + 17);  check_eq("loss.relock_stab", state, 2);
    run_to(base + 273); check_eq("loss.relock_run", state, 3);
    check_eq("loss.relock_ready", ready, 1);

    // relock_req in RUN coinciding with a synchronized lock drop.
    base = e;
    pll_locked = 1'b0;
    run_to(base + 2);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_eq("rq_run.state", state, 0);
    check_eq("rq_run.retry", retry_count, 0);
    check_eq("rq_run.loss_unchanged", lock_loss_count, 1);
    check_eq("rq_run.sys_low", sys_reset_n, 0);

    // Unstable lock: 4-cycle drop at cycle 100 of STABILIZE, then a clean second attempt.
    base = e;
    run_to(base + 16); check_eq("unst.wait", state, 1);
    pll_locked = 1'b1;
    s = base + 19;
    run_to(s - 1);   check_eq("unst.pre_stab", state, 1);
    run_to(s);       check_eq("unst.stab", state, 2);
    run_to(s + 99);  pll_locked = 1'b0;
    run_to(s + 101); check_eq("unst.still_stab", state, 2);
    run_to(s + 102); check_eq("unst.fail_state", state, 0);
    check_eq("unst.retry1", retry_count, 1);
    check_eq("unst.resetb_low", pll_resetb, 0);
    run_to(s + 103); pll_locked = 1'b1;
    r = s + 102;
    run_to(r + 16);  check_eq("unst.wait2", state, 1);
    run_to(r + 17);  check_eq("unst.stab2", state, 2);
    run_to(r + 272); check_eq("unst.retry_held", retry_count, 1);
    run_to(r + 273); check_eq("unst.run2", state, 3);
    check_eq("unst.retry_cleared", retry_count, 0);

    // Second lock loss, then reset_n asserted mid-STABILIZE.
    base = e;
    pll_locked = 1'b0;
    run_to(base + 3); check_eq("loss2.count", lock_loss_count, 2);
    pll_locked = 1'b1;
    base = e;
    run_to(base + 17); check_eq("midrst.stab", state, 2);
    run_to(base + 67);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    tick();
    check_reset_values("midrst");

    // No lock: four attempts then FAULT at 4*1016.
    e = 0;
    reset_n = 1'b1;
    run_to(16);   check_eq("nolock.resetb_high", pll_resetb, 1);
    run_to(1016); check_eq("nolock.retry1", retry_count, 1);
    check_eq("nolock.reset_again", pll_resetb, 0);
    run_to(1031); check_eq("nolock.hold2", pll_resetb, 0);
    run_to(1032); check_eq("nolock.release2", pll_resetb, 1);
    run_to(2032); check_eq("nolock.retry2", retry_count, 2);
    run_to(3048); check_eq("nolock.retry3", retry_count, 3);
    run_to(4063); check_eq("nolock.pre_fault", fault, 0);
    check_eq("nolock.pre_fault_state", state, 1);
    run_to(4064); check_eq("nolock.fault", fault, 1);
    check_eq("nolock.fault_state", state, 4);
    check_eq("nolock.fault_retry", retry_count, 3);
    check_eq("nolock.fault_resetb", pll_resetb, 0);
    run_to(4100); check_eq("nolock.fault_held", state, 4);

    // relock_req from FAULT.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_eq("rq_fault.state", state, 0);
    check_eq("rq_fault.fault", fault, 0);
    check_eq("rq_fault.retry", retry_count, 0);
    base = e;
    run_to(base + 16); check_eq("rq_fault.wait", state, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
